mcu_pmu: RTL



---
 rtl/mcu_pmu_if.sv | 38 +++
 rtl/mcu_pmu.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mcu_pmu_if.sv
// Power-management request/status bundle between the 8051 core side and the PMU.
// The master drives the PCON-derived requests and wake level.
// The slave (the PMU) drives the clock-gating and status outputs.
interface mcu_pmu_if;
  logic pmuintreq;
  logic idle_req;
  logic stop_req;
  logic cpu_clk_en;
  logic per_clk_en;
  logic osc_pd;
  logic idle_mode;
  logic stop_mode;
  logic wakeup;

  modport master (
    output pmuintreq,
    output idle_req,
    output stop_req,
    input  cpu_clk_en,
    input  per_clk_en,
    input  osc_pd,
    input  idle_mode,
    input  stop_mode,
    input  wakeup
  );

  modport slave (
    input  pmuintreq,
    input  idle_req,
    input  stop_req,
    output cpu_clk_en,
    output per_clk_en,
    output osc_pd,
    output idle_mode,
    output stop_mode,
    output wakeup
  );
endinterface

// File: rtl/mcu_pmu.sv
// Power-management unit for the 8051 core.
// It enters IDLE or STOP on PCON write pulses and gates the CPU and peripheral clocks.
// In STOP it also powers the oscillator down.
// On a wake request it restores the clocks, inserting an oscillator warm-up after STOP.
// A one-cycle wakeup pulse is issued on return to RUN so PCON.IDL/PD can be cleared.
// All outputs are registered and decoded from the next state, so they move on the
// same edge as the state.
module mcu_pmu #(
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input logic      clk,
  input logic      rst,
  mcu_pmu_if.slave bus
);

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StIdle   = 2'd1,
    StStop   = 2'd2,
    StWarmup = 2'd3
  } state_e;

  // The counter is loaded so that it reaches zero in the last warm-up cycle.
  localparam logic [CNT_W-1:0] WarmLoad = CNT_W'(WARMUP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic cpu_clk_en_q, cpu_clk_en_d;
  logic per_clk_en_q, per_clk_en_d;
  logic osc_pd_q,     osc_pd_d;
  logic idle_mode_q,  idle_mode_d;
  logic stop_mode_q,  stop_mode_d;
  logic wakeup_q,     wakeup_d;

  // State, counter and output registers; reset wins over everything, including warm-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      cnt_q        <= '0;
      cpu_clk_en_q <= 1'b1;
      per_clk_en_q <= 1'b1;
      osc_pd_q     <= 1'b0;
      idle_mode_q  <= 1'b0;
      stop_mode_q  <= 1'b0;
      wakeup_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cpu_clk_en_q <= cpu_clk_en_d;
      per_clk_en_q <= per_clk_en_d;
      osc_pd_q     <= osc_pd_d;
      idle_mode_q  <= idle_mode_d;
      stop_mode_q  <= stop_mode_d;
      wakeup_q     <= wakeup_d;
    end
  end

  // Next-state and warm-up counter; requests outside RUN are dropped, not queued.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StRun: begin
        // Stop has priority over idle when both are written together.
        if (bus.stop_req) begin
          state_d = StStop;
        end else if (bus.idle_req) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (bus.pmuintreq) begin
          state_d = StRun;
        end
      end
      StStop: begin
        if (bus.pmuintreq) begin
          state_d = StWarmup;
          cnt_d   = WarmLoad;
        end
      end
      StWarmup: begin
        // The wake is committed; pmuintreq is no longer looked at.
        if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  // Output decode from the next state; wakeup marks the exit edge back into RUN.
  always_comb begin
    cpu_clk_en_d = 1'b1;
    per_clk_en_d = 1'b1;
    osc_pd_d     = 1'b0;
    idle_mode_d  = 1'b0;
    stop_mode_d  = 1'b0;
    wakeup_d     = 1'b0;
    unique case (state_d)
      StRun: begin
        wakeup_d = (state_q == StIdle) || (state_q == StWarmup);
      end
      StIdle: begin
        cpu_clk_en_d = 1'b0;
        idle_mode_d  = 1'b1;
      end
      StStop: begin
        cpu_clk_en_d = 1'b0;
        per_clk_en_d = 1'b0;
        osc_pd_d     = 1'b1;
        stop_mode_d  = 1'b1;
      end
      StWarmup: begin
        cpu_clk_en_d = 1'b0;
        per_clk_en_d = 1'b0;
        stop_mode_d  = 1'b1;
      end
      default: begin
        cpu_clk_en_d = 1'b1;
      end
    endcase
  end

  assign bus.cpu_clk_en = cpu_clk_en_q;
  assign bus.per_clk_en = per_clk_en_q;
  assign bus.osc_pd     = osc_pd_q;
  assign bus.idle_mode  = idle_mode_q;
  assign bus.stop_mode  = stop_mode_q;
  assign bus.wakeup     = wakeup_q;

endmodule
